// File: rtl/vai_arbiter.sv
// vai_arbiter: round-robin arbiter sharing one framed register slave between two requesters.
module vai_arbiter #(
  parameter int C_TIMEOUT = 64
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic [7:0] Din0_i,
  input  logic       DinValid0_i,
  input  logic       DinStart0_i,
  input  logic       DinStop0_i,
  output logic       DinAccept0_o,
  input  logic [7:0] Din1_i,
  input  logic       DinValid1_i,
  input  logic       DinStart1_i,
  input  logic       DinStop1_i,
  output logic       DinAccept1_o,
  output logic [7:0] Dout0_o,
  output logic       DoutValid0_o,
  output logic       DoutStart0_o,
  output logic       DoutStop0_o,
  input  logic       DoutAccept0_i,
  output logic [7:0] Dout1_o,
  output logic       DoutValid1_o,
  output logic       DoutStart1_o,
  output logic       DoutStop1_o,
  input  logic       DoutAccept1_i,
  output logic [7:0] SlvDin_o,
  output logic       SlvDinValid_o,
  output logic       SlvDinStart_o,
  output logic       SlvDinStop_o,
  input  logic       SlvDinAccept_i,
  input  logic [7:0] SlvDout_i,
  input  logic       SlvDoutValid_i,
  input  logic       SlvDoutStart_i,
  input  logic       SlvDoutStop_i,
  output logic       SlvDoutAccept_o,
  output logic [1:0] Grant_o,
  output logic       Timeout_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_grant, w_grant_next;
  logic       r_last, w_last_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       r_timeout, w_timeout_next;
  logic       w_g, w_idle, w_req, w_rsp, w_req0, w_req1, w_win;
  assign w_g    = r_grant[1];
  assign w_idle = (r_state == IDLE);
  assign w_req  = (r_state == REQ);
  assign w_rsp  = (r_state == RSP);
  assign w_req0 = DinValid0_i & DinStart0_i;
  assign w_req1 = DinValid1_i & DinStart1_i;
  // On a tie the requester that was not granted last wins.
  assign w_win  = (w_req0 & w_req1) ? ~r_last : w_req1;
  always_comb begin
    w_next         = r_state;
    w_grant_next   = r_grant;
    w_last_next    = r_last;
    w_cnt_next     = 8'd0;
    w_timeout_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_next       = REQ;
          w_grant_next = w_win ? 2'b10 : 2'b01;
        end
      end
      REQ: w_next = (SlvDinValid_o & SlvDinStop_o & SlvDinAccept_i) ? RSP : REQ;
      RSP: begin
        w_cnt_next = SlvDoutValid_i ? 8'd0 : (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        if ((SlvDoutValid_i & SlvDoutStop_i & SlvDoutAccept_o) | (w_cnt_next == 8'(C_TIMEOUT))) begin
          w_next         = IDLE;
          w_grant_next   = 2'b00;
          w_last_next    = w_g;
          w_timeout_next = ~SlvDoutValid_i;
          w_cnt_next     = 8'd0;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_state   <= IDLE;
      r_grant   <= 2'b00;
      r_last    <= 1'b1;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_grant   <= w_grant_next;
      r_last    <= w_last_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
    end
  end
  assign SlvDin_o        = w_req ? (w_g ? Din1_i : Din0_i) : 8'd0;
  assign SlvDinValid_o   = w_req & (w_g ? DinValid1_i : DinValid0_i);
  assign SlvDinStart_o   = w_req & (w_g ? DinStart1_i : DinStart0_i);
  assign SlvDinStop_o    = w_req & (w_g ? DinStop1_i : DinStop0_i);
  // Stray non-start beats are swallowed in IDLE; reset gates this input-driven path.
  assign DinAccept0_o    = ~Reset_i & (w_idle ? DinValid0_i & ~DinStart0_i : w_req & ~w_g & SlvDinAccept_i);
  assign DinAccept1_o    = ~Reset_i & (w_idle ? DinValid1_i & ~DinStart1_i : w_req & w_g & SlvDinAccept_i);
  assign Dout0_o         = (w_rsp & ~w_g) ? SlvDout_i : 8'd0;
  assign DoutValid0_o    = w_rsp & ~w_g & SlvDoutValid_i;
  assign DoutStart0_o    = w_rsp & ~w_g & SlvDoutStart_i;
  assign DoutStop0_o     = w_rsp & ~w_g & SlvDoutStop_i;
  assign Dout1_o         = (w_rsp & w_g) ? SlvDout_i : 8'd0;
  assign DoutValid1_o    = w_rsp & w_g & SlvDoutValid_i;
  assign DoutStart1_o    = w_rsp & w_g & SlvDoutStart_i;
  assign DoutStop1_o     = w_rsp & w_g & SlvDoutStop_i;
  assign SlvDoutAccept_o = w_rsp & (w_g ? DoutAccept1_i : DoutAccept0_i);
  assign Grant_o         = r_grant;
  assign Timeout_o       = r_timeout;
endmodule

// File: tb/tb_vai_arbiter.sv
// tb_vai_arbiter: directed checks of arbitration, forwarding, backpressure, stray beats, timeout and reset.
module tb_vai_arbiter;
  logic       Clk_i = 1'b0, Reset_i = 1'b1;
  logic [7:0] Din0_i = 0, Din1_i = 0, SlvDout_i = 0;
  logic       DinValid0_i = 0, DinStart0_i = 0, DinStop0_i = 0;
  logic       DinValid1_i = 0, DinStart1_i = 0, DinStop1_i = 0;
  logic       DoutAccept0_i = 0, DoutAccept1_i = 0, SlvDinAccept_i = 0;
  logic       SlvDoutValid_i = 0, SlvDoutStart_i = 0, SlvDoutStop_i = 0;
  logic       DinAccept0_o, DinAccept1_o, SlvDinValid_o, SlvDinStart_o, SlvDinStop_o, SlvDoutAccept_o, Timeout_o;
  logic [7:0] Dout0_o, Dout1_o, SlvDin_o;
  logic       DoutValid0_o, DoutStart0_o, DoutStop0_o, DoutValid1_o, DoutStart1_o, DoutStop1_o;
  logic [1:0] Grant_o;
  int n_chk = 0, n_err = 0;
  vai_arbiter #(.C_TIMEOUT(4)) dut (
    .Clk_i(Clk_i), .Reset_i(Reset_i),
    .Din0_i(Din0_i), .DinValid0_i(DinValid0_i), .DinStart0_i(DinStart0_i), .DinStop0_i(DinStop0_i), .DinAccept0_o(DinAccept0_o),
    .Din1_i(Din1_i), .DinValid1_i(DinValid1_i), .DinStart1_i(DinStart1_i), .DinStop1_i(DinStop1_i), .DinAccept1_o(DinAccept1_o),
    .Dout0_o(Dout0_o), .DoutValid0_o(DoutValid0_o), .DoutStart0_o(DoutStart0_o), .DoutStop0_o(DoutStop0_o), .DoutAccept0_i(DoutAccept0_i),
    .Dout1_o(Dout1_o), .DoutValid1_o(DoutValid1_o), .DoutStart1_o(DoutStart1_o), .DoutStop1_o(DoutStop1_o), .DoutAccept1_i(DoutAccept1_i),
    .SlvDin_o(SlvDin_o), .SlvDinValid_o(SlvDinValid_o), .SlvDinStart_o(SlvDinStart_o), .SlvDinStop_o(SlvDinStop_o), .SlvDinAccept_i(SlvDinAccept_i),
    .SlvDout_i(SlvDout_i), .SlvDoutValid_i(SlvDoutValid_i), .SlvDoutStart_i(SlvDoutStart_i), .SlvDoutStop_i(SlvDoutStop_i), .SlvDoutAccept_o(SlvDoutAccept_o),
    .Grant_o(Grant_o), .Timeout_o(Timeout_o)
  );
  always #5 Clk_i = ~Clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk_i);
    #1;
  endtask
  task automatic slv(input logic [7:0] d, input logic v, input logic s, input logic p);
    SlvDout_i = d; SlvDoutValid_i = v; SlvDoutStart_i = s; SlvDoutStop_i = p;
  endtask
  initial begin
    DinValid1_i = 1;
    #2;
    chk("rst_grant", Grant_o, 2'b00);
    chk("rst_acc1", DinAccept1_o, 0);
    chk("rst_slvv", SlvDinValid_o, 0);
    chk("rst_to", Timeout_o, 0);
    DinValid1_i = 0;
    step(); Reset_i = 0; step();
    // read from requester 0
    Din0_i = 8'h30; DinValid0_i = 1; DinStart0_i = 1; DinStop0_i = 1; SlvDinAccept_i = 1;
    #1;
    chk("idle_noacc", DinAccept0_o, 0);
    chk("idle_slvv", SlvDinValid_o, 0);
    step(); #1;
    chk("rd_grant", Grant_o, 2'b01);
    chk("rd_slvdin", SlvDin_o, 8'h30);
    chk("rd_slvse", {SlvDinValid_o, SlvDinStart_o, SlvDinStop_o}, 3'b111);
    chk("rd_acc", {DinAccept1_o, DinAccept0_o}, 2'b01);
    step(); DinValid0_i = 0; SlvDinAccept_i = 0; DoutAccept0_i = 1; slv(8'h30, 1, 1, 0); #1;
    chk("rd_d0", Dout0_o, 8'h30);
    chk("rd_vs0", {DoutValid0_o, DoutStart0_o, DoutStop0_o}, 3'b110);
    chk("rd_v1", DoutValid1_o, 0);
    chk("rd_sacc", SlvDoutAccept_o, 1);
    step(); slv(8'hAB, 1, 0, 0); DoutAccept0_i = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_sacc", SlvDoutAccept_o, 0);
      chk("bp_d0", Dout0_o, 8'hAB);
      chk("bp_v1", DoutValid1_o, 0);
      step();
    end
    DoutAccept0_i = 1; #1;
    chk("bp_rel", SlvDoutAccept_o, 1);
    step(); slv(8'h00, 1, 0, 1); #1;
    chk("rd_stop", {DoutValid0_o, DoutStop0_o, Dout0_o}, {2'b11, 8'h00});
    chk("rd_grant2", Grant_o, 2'b01);
    step(); #1;
    chk("rd_end", Grant_o, 2'b00);
    chk("rd_v0off", DoutValid0_o, 0);
    chk("rd_saccoff", SlvDoutAccept_o, 0);
    slv(0, 0, 0, 0); DoutAccept0_i = 0;
    // stray beat
    DinValid1_i = 1; DinStart1_i = 0; #1;
    chk("stray_acc", DinAccept1_o, 1);
    chk("stray_slvv", SlvDinValid_o, 0);
    step();
    chk("stray_grant", Grant_o, 2'b00);
    DinValid1_i = 0;
    // tie after reset
    #1 Reset_i = 1; #2 Reset_i = 0;
    step();
    Din0_i = 8'h11; DinValid0_i = 1; DinStart0_i = 1; DinStop0_i = 1;
    Din1_i = 8'h22; DinValid1_i = 1; DinStart1_i = 1; DinStop1_i = 1;
    step();
    chk("tie1_grant", Grant_o, 2'b01);
    chk("tie1_din", SlvDin_o, 8'h11);
    chk("tie1_acc1", DinAccept1_o, 0);
    SlvDinAccept_i = 1;
    step(); DinValid0_i = 0; SlvDinAccept_i = 0; DoutAccept0_i = 1; slv(8'h5A, 1, 1, 1); #1;
    chk("tie1_d0", Dout0_o, 8'h5A);
    chk("tie1_v1", DoutValid1_o, 0);
    chk("tie1_acc1rsp", DinAccept1_o, 0);
    step(); slv(0, 0, 0, 0); DoutAccept0_i = 0; #1;
    chk("tie1_end", Grant_o, 2'b00);
    chk("tie_idle_noacc1", DinAccept1_o, 0);
    step();
    chk("tie2_grant", Grant_o, 2'b10);
    chk("tie2_din", SlvDin_o, 8'h22);
    SlvDinAccept_i = 1; #1;
    chk("tie2_acc", {DinAccept1_o, DinAccept0_o}, 2'b10);
    step(); DinValid1_i = 0; SlvDinAccept_i = 0; DoutAccept1_i = 1; slv(8'h77, 1, 1, 1); #1;
    chk("tie2_d1", Dout1_o, 8'h77);
    chk("tie2_d0", {DoutValid0_o, Dout0_o}, 9'h0);
    chk("tie2_sacc", SlvDoutAccept_o, 1);
    step(); slv(0, 0, 0, 0); DoutAccept1_i = 0; #1;
    chk("tie2_end", Grant_o, 2'b00);
    DinValid0_i = 1; DinValid1_i = 1; DinStart1_i = 1;
    step();
    chk("tie3_grant", Grant_o, 2'b01);
    // reset mid-REQ
    Reset_i = 1; #1;
    chk("rreq_grant", Grant_o, 2'b00);
    chk("rreq_slvv", SlvDinValid_o, 0);
    chk("rreq_acc", {DinAccept1_o, DinAccept0_o}, 2'b00);
    Reset_i = 0;
    step();
    chk("rreq_tie", Grant_o, 2'b01);
    // timeout with silent slave
    SlvDinAccept_i = 1;
    step(); DinValid0_i = 0; DinValid1_i = 0; SlvDinAccept_i = 0; #1;
    chk("to_start", Timeout_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait", {Grant_o, Timeout_o}, 3'b010);
    end
    step();
    chk("to_pulse", {Grant_o, Timeout_o}, 3'b001);
    step();
    chk("to_clear", Timeout_o, 0);
    DinValid0_i = 1; DinValid1_i = 1;
    step();
    chk("to_last", Grant_o, 2'b10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vai_arbiter.md
VAI_ARBITER -- requirements
Module: vai_arbiter

Interface
REQ-001 SHALL have parameter C_TIMEOUT, default 64: number of consecutive idle response cycles before a frame is aborted (range 2..255).
REQ-002 SHALL have port Clk_i, in, 1 bit: single clock; all logic on rising edge.
REQ-003 SHALL have port Reset_i, in, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports Din0_i and Din1_i, in, 8 bits each: requester request data.
REQ-005 SHALL have ports DinValid0_i/DinStart0_i/DinStop0_i and DinValid1_i/DinStart1_i/DinStop1_i, in, 1 bit each: requester request framing.
REQ-006 SHALL have ports DinAccept0_o and DinAccept1_o, out, 1 bit each: request beat accepted.
REQ-007 SHALL have ports Dout0_o and Dout1_o, out, 8 bits each, plus DoutValid0_o/DoutStart0_o/DoutStop0_o and DoutValid1_o/DoutStart1_o/DoutStop1_o, out, 1 bit each: responses to the requesters.
REQ-008 SHALL have ports DoutAccept0_i and DoutAccept1_i, in, 1 bit each: requester response acceptance.
REQ-009 SHALL have ports SlvDin_o (out, 8 bits) and SlvDinValid_o/SlvDinStart_o/SlvDinStop_o (out, 1 bit each), plus SlvDinAccept_i (in, 1 bit): request port to the shared register slave.
REQ-010 SHALL have ports SlvDout_i (in, 8 bits) and SlvDoutValid_i/SlvDoutStart_i/SlvDoutStop_i (in, 1 bit each), plus SlvDoutAccept_o (out, 1 bit): response port from the slave.
REQ-011 SHALL have port Grant_o, out, 2 bits: one-hot current owner; 00 in IDLE.
REQ-012 SHALL have port Timeout_o, out, 1 bit: one-cycle pulse on frame abort.

Function
REQ-013 SHALL implement the states IDLE, REQ and RSP in a registered FSM.
REQ-014 SHALL treat requester n as requesting in IDLE when DinValidn_i && DinStartn_i.
REQ-015 SHALL arbitrate round-robin in IDLE: a single requester wins; if both request, the one not granted last wins.
REQ-016 SHALL register the grant in Grant_o, move IDLE->REQ on the next edge, and accept no start beat while in IDLE (1 cycle arbitration latency).
REQ-017 SHALL accept and discard, in IDLE, any beat with DinValidn_i && !DinStartn_i (DinAcceptn_o=1, not forwarded).
REQ-018 SHALL in REQ combinationally connect the granted requester's Din/Valid/Start/Stop to SlvDin*, and drive DinAcceptg_o = SlvDinAccept_i.
REQ-019 SHALL in REQ hold the non-granted DinAccept at 0.
REQ-020 SHALL go REQ->RSP on the edge where SlvDinValid_o && SlvDinStop_o && SlvDinAccept_i.
REQ-021 SHALL in RSP connect SlvDout*/SlvDoutValid_i/Start/Stop to the granted requester's Dout* outputs and drive SlvDoutAccept_o = DoutAcceptg_i.
REQ-022 SHALL in RSP hold the non-granted DoutValid at 0.
REQ-023 SHALL go RSP->IDLE, clear Grant_o and record the last grant on the edge where SlvDoutValid_i && SlvDoutStop_i && SlvDoutAccept_o.
REQ-024 SHALL, outside REQ, drive SlvDinValid_o=0; outside RSP, drive SlvDoutAccept_o=0 and both DoutValid=0; unused data outputs SHALL be 0.
REQ-025 SHALL count consecutive RSP cycles with SlvDoutValid_i=0 (8-bit, saturating, cleared on any valid beat).
REQ-026 SHALL, when the count reaches C_TIMEOUT, go to IDLE, pulse Timeout_o for 1 cycle, and record the grant as last granted.
REQ-027 SHALL add no latency on data paths beyond the combinational mux; stall/stability is inherited from the upstream sources.

Reset
REQ-028 SHALL while Reset_i=1 immediately force state IDLE, Grant_o=00, all Valid/Accept/Start/Stop outputs 0, data outputs 0, Timeout_o=0 and timeout count 0.
REQ-029 SHALL set the last-granted register to requester 1 on reset, so requester 0 wins the first tie.
REQ-030 SHALL abort a frame in progress when reset is asserted mid-frame, without completing it.

Verification
REQ-031 Read from 0: Din0=0x30 start+stop -> Grant_o=01 next cycle, SlvDin_o=0x30; slave returns 0x30(start), 0xAB, 0x00(stop) -> same on Dout0, DoutValid1_o=0 throughout, Grant_o=00 after stop.
REQ-032 Tie: both post start beats after reset -> requester 0's frame served first, then requester 1; on the next tie, 0 wins again.
REQ-033 Backpressure: DoutAccept0_i=0 for 3 cycles mid-response -> SlvDoutAccept_o=0 those cycles, Dout0_o stable.
REQ-034 Stray beat: DinValid1_i=1, DinStart1_i=0 in IDLE -> DinAccept1_o=1, SlvDinValid_o=0, Grant_o=00.
REQ-035 Timeout: C_TIMEOUT=4, slave silent after request -> Timeout_o=1 exactly 4 cycles into RSP, then IDLE.
REQ-036 Reset in REQ -> outputs 0 asynchronously; after release, a tie grants requester 0.
